// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART sender among N
// byte producers. Each producer hands over a byte through a four-phase req/ack
// handshake. The byte is latched into a holding register, the producer is
// released, and the same four-phase handshake is then replayed toward the
// sender.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to build the sender-acknowledge
// timeout. It sets the sticky err flag and drops the byte if snd_ack does not
// arrive within TO_CYCLES cycles in SREQ. Without the macro, err is tied low
// and SREQ waits without limit.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; arbitrate among src_req, scanning upward from last+1
// GRANT | src_ack[grant_id] high; wait for the producer to drop its request
// SREQ  | snd_req high toward the sender; wait for snd_ack
// SREL  | snd_req low; wait for snd_ack to fall before accepting a new grant

module uart_tx_arbiter #(
   parameter int N         = 4,
   parameter int ID_W      = 2,
   parameter int TO_CYCLES = 4095
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [N-1:0]    src_req,
   input  logic [8*N-1:0]  src_data,
   output logic [N-1:0]    src_ack,
   output logic            snd_req,
   output logic [7:0]      snd_data,
   input  logic            snd_ack,
   output logic            busy,
   output logic [ID_W-1:0] grant_id,
   output logic            err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SREQ  = 2'd2,
      SREL  = 2'd3
   } state_t;

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N - 1);

   // Reject parameter sets the arbiter cannot represent.
   if (N < 2 || N > 8 || (1 << ID_W) < N || TO_CYCLES < 1 || TO_CYCLES > 4095) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported N/ID_W/TO_CYCLES combination");
   end

   state_t          state;
   logic [ID_W-1:0] last;
   logic [7:0]      hold;
   logic            pick_vld;
   logic [ID_W-1:0] pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
   // Down-counter loaded on SREQ entry; terminal count 0 ends the TO_CYCLES-th
   // cycle spent in SREQ.
   localparam logic [11:0] TO_LOAD = 12'(TO_CYCLES - 1);
   logic [11:0] tmr;
   logic        err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign snd_data = hold;

   // Rotating priority: the first requester found at last+1, last+2, ... (mod N).
   // The loop runs from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      int cand;
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      for (int k = N; k >= 1; k--) begin
         cand = (int'(last) + k) % N;
         if (src_req[cand[ID_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[ID_W-1:0];
         end
      end
   end

   // Handshake FSM with registered outputs. The holding register is written
   // only on the grant, so the sender sees a stable byte through SREL.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         last     <= LAST_RST;
         hold     <= '0;
         grant_id <= '0;
         src_ack  <= '0;
         snd_req  <= 1'b0;
         busy     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         tmr      <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  hold     <= src_data[{pick_idx, 3'b000} +: 8];
                  grant_id <= pick_idx;
                  last     <= pick_idx;
                  src_ack  <= N'(1) << pick_idx;
                  busy     <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (!src_req[grant_id]) begin
                  src_ack <= '0;
                  snd_req <= 1'b1;
                  state   <= SREQ;
`ifdef UART_ARB_TIMEOUT_EN
                  tmr     <= TO_LOAD;
`endif
               end
            end
            SREQ: begin
               if (snd_ack) begin
                  snd_req <= 1'b0;
                  state   <= SREL;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (tmr == '0) begin
                  // Sender never answered: drop the byte, keep the rotation.
                  snd_req <= 1'b0;
                  busy    <= 1'b0;
                  err_q   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  tmr <= tmr - 12'd1;
               end
`endif
            end
            SREL: begin
               if (!snd_ack) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
